// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Owner encoding, FSM states and latency bounds.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_EXT = 1'b1;

  localparam int CNT_W   = 4;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;

  function automatic bit lat_ok(input int lat);
    return (lat >= LAT_MIN) && (lat <= LAT_MAX);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker for the data-memory arbiter.
// A tie goes to the port that did not win the previous grant.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       enable,
  output logic       grant_valid,
  output logic       grant_owner
);

  logic last_owner;

  always_comb begin
    grant_valid = enable & (|req);
    grant_owner = OWN_CPU;
    unique case (req)
      2'b11:   grant_owner = ~last_owner;
      2'b10:   grant_owner = OWN_EXT;
      default: grant_owner = OWN_CPU;
    endcase
  end

  // Reset to EXT so the CPU wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= OWN_EXT;
    end else if (grant_valid) begin
      last_owner <= grant_owner;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the CPU and an external port.
// One transaction at a time: grant, strobe, fixed-latency wait, done.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_done_o,
  output logic              cpu_stall_o,
  input  logic              ext_req_i,
  input  logic              ext_we_i,
  input  logic [ADDR_W-1:0] ext_addr_i,
  input  logic [DATA_W-1:0] ext_wdata_i,
  output logic [DATA_W-1:0] ext_rdata_o,
  output logic              ext_done_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  if (!lat_ok(MEM_LAT)) begin : g_lat_err
    $error("dmem_arbiter: MEM_LAT must be 1..15");
  end

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  state_t            state;
  state_t            nxt;
  logic              owner;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] ext_rdata_q;
  logic              grant_valid;
  logic              grant_owner;

  rr_arb2 u_arb (
    .clk         (clk_i),
    .rst_n       (rst_i),
    .req         ({ext_req_i, cpu_req_i}),
    .enable      (state == IDLE),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (grant_valid) nxt = ISSUE;
      ISSUE: nxt = WAIT;
      WAIT:  if (cnt == '0) nxt = RESP;
      RESP:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      owner       <= OWN_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt         <= '0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      state <= nxt;
      unique case (state)
        IDLE: begin
          if (grant_valid) begin
            owner <= grant_owner;
            if (grant_owner == OWN_EXT) begin
              we_q    <= ext_we_i;
              addr_q  <= ext_addr_i;
              wdata_q <= ext_wdata_i;
            end else begin
              we_q    <= cpu_we_i;
              addr_q  <= cpu_addr_i;
              wdata_q <= cpu_wdata_i;
            end
          end
        end
        ISSUE: cnt <= CNT_INIT;
        WAIT: begin
          if (cnt == '0) begin
            if (!we_q && owner == OWN_CPU) cpu_rdata_q <= mem_rdata_i;
            if (!we_q && owner == OWN_EXT) ext_rdata_q <= mem_rdata_i;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_read_o  = (state == ISSUE) & ~we_q;
  assign mem_write_o = (state == ISSUE) & we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  assign cpu_done_o  = (state == RESP) & (owner == OWN_CPU);
  assign ext_done_o  = (state == RESP) & (owner == OWN_EXT);
  assign cpu_rdata_o = cpu_rdata_q;
  assign ext_rdata_o = ext_rdata_q;
  assign cpu_stall_o = cpu_req_i & ~cpu_done_o;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter at MEM_LAT=2 (dut a) and 1 (dut b).
// Both instances share stimulus; checks target one at a time.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        ext_req = 1'b0;
  logic        ext_we = 1'b0;
  logic [31:0] ext_addr = '0;
  logic [31:0] ext_wdata = '0;
  logic [31:0] mem_rdata = '0;

  logic [31:0] a_cpu_rdata, a_ext_rdata, a_addr, a_wdata;
  logic        a_cpu_done, a_cpu_stall, a_ext_done, a_rd, a_wr;
  logic [31:0] b_cpu_rdata, b_ext_rdata, b_addr, b_wdata;
  logic        b_cpu_done, b_cpu_stall, b_ext_done, b_rd, b_wr;

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_LAT(2)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we),
    .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(a_cpu_rdata), .cpu_done_o(a_cpu_done),
    .cpu_stall_o(a_cpu_stall),
    .ext_req_i(ext_req), .ext_we_i(ext_we),
    .ext_addr_i(ext_addr), .ext_wdata_i(ext_wdata),
    .ext_rdata_o(a_ext_rdata), .ext_done_o(a_ext_done),
    .mem_addr_o(a_addr), .mem_wdata_o(a_wdata),
    .mem_read_o(a_rd), .mem_write_o(a_wr),
    .mem_rdata_i(mem_rdata)
  );

  dmem_arbiter #(.MEM_LAT(1)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we),
    .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(b_cpu_rdata), .cpu_done_o(b_cpu_done),
    .cpu_stall_o(b_cpu_stall),
    .ext_req_i(ext_req), .ext_we_i(ext_we),
    .ext_addr_i(ext_addr), .ext_wdata_i(ext_wdata),
    .ext_rdata_o(b_ext_rdata), .ext_done_o(b_ext_done),
    .mem_addr_o(b_addr), .mem_wdata_o(b_wdata),
    .mem_read_o(b_rd), .mem_write_o(b_wr),
    .mem_rdata_i(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge (start of next cycle).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic rst_pulse();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    // ---- reset state ----
    #2 cpu_req = 1'b1;
    #1;
    chk("rst_stall_hi", 32'(a_cpu_stall), 32'd1);
    chk("rst_cpu_done", 32'(a_cpu_done), 32'd0);
    chk("rst_ext_done", 32'(a_ext_done), 32'd0);
    chk("rst_strobes", {30'd0, a_rd, a_wr}, 32'd0);
    chk("rst_addr", a_addr, 32'd0);
    chk("rst_cpu_rdata", a_cpu_rdata, 32'd0);
    chk("rst_ext_rdata", a_ext_rdata, 32'd0);
    cpu_req = 1'b0;
    #1;
    chk("rst_stall_lo", 32'(a_cpu_stall), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    // ---- CPU load, MEM_LAT=2 ----
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    mem_rdata = 32'h0BAD0BAD;
    mid();
    chk("ld_c0_rd", 32'(a_rd), 32'd0);
    chk("ld_c0_stall", 32'(a_cpu_stall), 32'd1);
    cyc();
    mid();
    chk("ld_c1_rd", 32'(a_rd), 32'd1);
    chk("ld_c1_wr", 32'(a_wr), 32'd0);
    chk("ld_c1_addr", a_addr, 32'h10);
    chk("ld_c1_stall", 32'(a_cpu_stall), 32'd1);
    cyc();
    mid();
    chk("ld_c2_rd", 32'(a_rd), 32'd0);
    chk("ld_c2_done", 32'(a_cpu_done), 32'd0);
    cyc();
    mem_rdata = 32'hDEADBEEF;
    mid();
    chk("ld_c3_done", 32'(a_cpu_done), 32'd0);
    chk("ld_c3_stall", 32'(a_cpu_stall), 32'd1);
    cyc();
    mem_rdata = 32'h0BAD0BAD;
    mid();
    chk("ld_c4_done", 32'(a_cpu_done), 32'd1);
    chk("ld_c4_rdata", a_cpu_rdata, 32'hDEADBEEF);
    chk("ld_c4_stall", 32'(a_cpu_stall), 32'd0);
    chk("ld_c4_ext_done", 32'(a_ext_done), 32'd0);
    cyc();
    cpu_req = 1'b0;
    mid();
    chk("ld_c5_done", 32'(a_cpu_done), 32'd0);
    chk("ld_c5_rdata", a_cpu_rdata, 32'hDEADBEEF);
    cyc();

    // ---- tie after reset: CPU store first, then ext load ----
    rst_pulse();
    cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 32'h20; cpu_wdata = 32'h55;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h40;
    cyc();
    mid();
    chk("tie_c1_wr", 32'(a_wr), 32'd1);
    chk("tie_c1_rd", 32'(a_rd), 32'd0);
    chk("tie_c1_addr", a_addr, 32'h20);
    chk("tie_c1_wdata", a_wdata, 32'h55);
    cyc(); cyc(); cyc();
    mid();
    chk("tie_c4_cdone", 32'(a_cpu_done), 32'd1);
    chk("tie_c4_edone", 32'(a_ext_done), 32'd0);
    chk("tie_c4_crdata", a_cpu_rdata, 32'd0);
    cyc();
    cpu_req = 1'b0;
    mid();
    chk("tie_c5_rd", 32'(a_rd), 32'd0);
    chk("tie_c5_addr_hold", a_addr, 32'h20);
    cyc();
    mid();
    chk("tie_c6_rd", 32'(a_rd), 32'd1);
    chk("tie_c6_addr", a_addr, 32'h40);
    cyc(); cyc();
    mem_rdata = 32'h12345678;
    cyc();
    mem_rdata = 32'h0BAD0BAD;
    mid();
    chk("tie_c9_edone", 32'(a_ext_done), 32'd1);
    chk("tie_c9_erdata", a_ext_rdata, 32'h12345678);
    chk("tie_c9_cdone", 32'(a_cpu_done), 32'd0);
    cyc();

    // ---- both held: alternate CPU, EXT, CPU, EXT ----
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h200;
    mem_rdata = 32'hA5A5A5A5;
    for (int k = 0; k < 20; k++) begin
      mid();
      chk($sformatf("rr_cdone_k%0d", k), 32'(a_cpu_done),
          32'((k == 4) || (k == 14)));
      chk($sformatf("rr_edone_k%0d", k), 32'(a_ext_done),
          32'((k == 9) || (k == 19)));
      cyc();
    end
    cpu_req = 1'b0; ext_req = 1'b0;
    cyc();

    // ---- ext load with inputs changing in WAIT ----
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h80;
    mem_rdata = 32'h0BAD0BAD;
    cyc();
    mid();
    chk("ext_c1_rd", 32'(a_rd), 32'd1);
    chk("ext_c1_addr", a_addr, 32'h80);
    cyc();
    ext_req = 1'b0; ext_addr = 32'hFF;
    mid();
    chk("ext_c2_addr", a_addr, 32'h80);
    cyc();
    mem_rdata = 32'hCAFEF00D;
    mid();
    chk("ext_c3_addr", a_addr, 32'h80);
    cyc();
    mem_rdata = 32'h0BAD0BAD;
    mid();
    chk("ext_c4_edone", 32'(a_ext_done), 32'd1);
    chk("ext_c4_erdata", a_ext_rdata, 32'hCAFEF00D);
    chk("ext_c4_crdata", a_cpu_rdata, 32'hA5A5A5A5);
    chk("ext_c4_cdone", 32'(a_cpu_done), 32'd0);
    cyc();

    // ---- reset in WAIT, then a normal CPU load ----
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30;
    cyc();
    cyc();
    cpu_req = 1'b0;
    #3 rst = 1'b0;
    #1;
    chk("wrst_cdone", 32'(a_cpu_done), 32'd0);
    chk("wrst_strobes", {30'd0, a_rd, a_wr}, 32'd0);
    chk("wrst_crdata", a_cpu_rdata, 32'd0);
    chk("wrst_erdata", a_ext_rdata, 32'd0);
    chk("wrst_addr", a_addr, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    mid();
    chk("wrst_idle_rd", 32'(a_rd), 32'd0);
    cyc();
    cpu_req = 1'b1; cpu_addr = 32'h34;
    cyc();
    mid();
    chk("wrst_c1_rd", 32'(a_rd), 32'd1);
    chk("wrst_c1_addr", a_addr, 32'h34);
    cyc();
    cyc();
    mem_rdata = 32'h11112222;
    mid();
    chk("wrst_c3_done", 32'(a_cpu_done), 32'd0);
    cyc();
    mem_rdata = 32'h0BAD0BAD;
    mid();
    chk("wrst_c4_done", 32'(a_cpu_done), 32'd1);
    chk("wrst_c4_rdata", a_cpu_rdata, 32'h11112222);
    cyc();
    cpu_req = 1'b0;
    cyc();

    // ---- MEM_LAT=1 CPU load on dut b ----
    rst_pulse();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h44;
    mid();
    chk("l1_c0_rd", 32'(b_rd), 32'd0);
    cyc();
    mid();
    chk("l1_c1_rd", 32'(b_rd), 32'd1);
    chk("l1_c1_addr", b_addr, 32'h44);
    cyc();
    mem_rdata = 32'h77778888;
    mid();
    chk("l1_c2_rd", 32'(b_rd), 32'd0);
    chk("l1_c2_done", 32'(b_cpu_done), 32'd0);
    cyc();
    mem_rdata = 32'h0BAD0BAD;
    mid();
    chk("l1_c3_done", 32'(b_cpu_done), 32'd1);
    chk("l1_c3_rdata", b_cpu_rdata, 32'h77778888);
    chk("l1_c3_stall", 32'(b_cpu_stall), 32'd0);
    cyc();
    cpu_req = 1'b0;
    mid();
    chk("l1_c4_done", 32'(b_cpu_done), 32'd0);
    chk("l1_c4_rdata", b_cpu_rdata, 32'h77778888);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
